antisat_key_loader: RTL and testbench
=====================================

Name: antisat_key_loader

Overview:
- Sequences key activation for an Anti-SAT-locked combinational core.
- Receives the key serially over a valid/ready stream with one trailing even-parity bit, assembles it in a shadow register, and checks the parity.
- On a good check, commits the key atomically to the core's key bus and unmasks the core outputs.
- The core never sees a partial key; its outputs are forced to 0 until a key has been committed.

Parameters:
- KEY_W, 11, width of the key bus driven to the locked core.
- OUT_W, 2, number of locked-core outputs passed through the output gate.
- MAX_FAIL, 3, failed-load threshold; used only when lockout is compiled in.
- FAIL_W, 2, width of the fail counter; must hold MAX_FAIL.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a (re)load; level-sampled each cycle.
- kin_valid  in  1  serial key bit valid.
- kin_bit  in  1  serial key/parity bit.
- kin_ready  out  1  loader accepts a bit this cycle.
- key  out  KEY_W  committed key to the locked core.
- key_valid  out  1  committed key is live.
- busy  out  1  a load is in progress (SHIFT or CHECK).
- load_err  out  1  one-cycle pulse on parity failure.
- fail_cnt  out  FAIL_W  saturating count of failed loads.
- locked  out  1  permanent lockout (tied 0 without LOCKOUT_EN).
- obf_in  in  OUT_W  raw outputs of the locked core.
- obf_out  out  OUT_W  gated outputs: obf_in when key_valid=1, else 0 (combinational).

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE. The following clear to 0: key, key_valid, load_err, fail_cnt, locked, the shadow register and the bit counter. All outputs are therefore 0 in reset.
- A bit transfer occurs on any edge where kin_valid && kin_ready.
- kin_ready=1 only in SHIFT.
- busy=1 in SHIFT and CHECK.
- IDLE:
  - start=1 -> SHIFT; bit counter and shadow cleared.
  - kin_valid is ignored.
- SHIFT:
  - Transfers 0..KEY_W-1 write shadow[cnt], LSB first, then cnt++.
  - Transfer number KEY_W is the parity bit; it is latched and the state goes to CHECK.
  - Gaps in kin_valid are allowed; nothing advances without a transfer.
  - start is ignored.
- CHECK (exactly 1 cycle; kin_ready=0, start ignored):
  - Pass when (^shadow ^ parity)==0.
  - Pass: key<=shadow, key_valid<=1, next state ACTIVE.
  - Fail: key stays 0, key_valid stays 0, load_err=1 for this one edge's result, fail_cnt increments (saturating at all-ones), next state IDLE.
- ACTIVE:
  - key is held and key_valid=1.
  - start=1: next edge clears key_valid and key to 0, and the state goes to SHIFT (counter and shadow cleared).
- Latency: if the parity transfer happens at edge t, key and key_valid update at edge t+2.
- Simultaneous events: start together with kin_valid in IDLE only starts the load; that bit is not consumed.
- fail_cnt clears only on reset.

Optional Feature:
- Macro: ANTISAT_LOCKOUT_EN.
- Defined:
  - An additional state, LOCKOUT.
  - A failing CHECK that makes fail_cnt reach MAX_FAIL goes to LOCKOUT instead of IDLE.
  - In LOCKOUT: locked=1, kin_ready=0, start ignored, key=0, key_valid=0. Exit only via rst_n.
- Undefined:
  - No LOCKOUT state exists.
  - locked is tied to 0.
  - fail_cnt saturates and is informational only.

Decomposition:
- Package antisat_pkg:
  - State enum: IDLE, SHIFT, CHECK, ACTIVE, LOCKOUT.
  - Default KEY_W/OUT_W/MAX_FAIL constants.
  - Even-parity function.
- One sub-module: antisat_key_shreg.
  - Contains the shadow register, bit counter and parity latch.
  - Inputs: clr, shift enable, bit.
  - Outputs: shadow, parity, last_bit flag.
- The FSM, commit register and output gate remain in the top.

Test Plan:
- Reset release, then idle 10 cycles -> key=0, key_valid=0, kin_ready=0, obf_out=0 while obf_in=2'b11.
- start, then stream 11'h5A3 LSB first followed by parity 0 -> key_valid=1 and key=11'h5A3 exactly 2 edges after the parity transfer; obf_out tracks obf_in.
- Same key with parity 1 -> one-cycle load_err, fail_cnt=1, key_valid=0, back in IDLE (kin_ready=0); obf_out stays 0.
- In ACTIVE, start, then stream 11'h7FF with parity 1 using random kin_valid gaps -> key_valid drops the next edge (obf_out=0 during the reload), then key=11'h7FF and key_valid=1.
- Reset asserted after 5 bits in SHIFT -> immediate IDLE with all outputs 0; a following full load of 11'h001 with parity 1 succeeds.
- With ANTISAT_LOCKOUT_EN defined: three bad-parity loads -> locked=1, fail_cnt=3, and a further start is ignored. rst_n clears the lockout.

Source files
------------

// File: rtl/antisat_pkg.sv
// Shared types, default sizes and helpers for the Anti-SAT key loader.
package antisat_pkg;

  localparam int unsigned KEY_W_DEF    = 11;
  localparam int unsigned OUT_W_DEF    = 2;
  localparam int unsigned MAX_FAIL_DEF = 3;
  localparam int unsigned FAIL_W_DEF   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StActive,
    StLockout
  } state_e;

  // Reduction XOR; zero-extension of narrower keys leaves the result unchanged.
  function automatic logic parity_of(logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/antisat_key_shreg.sv
// Shadow register, bit counter and parity latch for the serial key stream.
module antisat_key_shreg
  import antisat_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             parity_o,
  output logic             last_bit_o
);

  localparam int unsigned CntW = $clog2(KEY_W + 1);

  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             parity_q, parity_d;
  logic             done_q, done_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    done_d   = done_q;
    if (clr_i) begin
      shadow_d = '0;
      cnt_d    = '0;
      parity_d = 1'b0;
      done_d   = 1'b0;
    end else if (shift_en_i && !done_q) begin
      // After KEY_W data bits the next transfer is the parity bit.
      if (cnt_q == CntW'(KEY_W)) begin
        parity_d = bit_i;
        done_d   = 1'b1;
      end else begin
        shadow_d[cnt_q] = bit_i;
        cnt_d           = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  assign shadow_o   = shadow_q;
  assign parity_o   = parity_q;
  assign last_bit_o = done_q;

endmodule

// File: rtl/antisat_key_loader.sv
// Key activation sequencer for an Anti-SAT-locked core: serial load, parity check,
// atomic commit and output gating. Define ANTISAT_LOCKOUT_EN for permanent lockout.
module antisat_key_loader
  import antisat_pkg::*;
#(
  parameter int unsigned KEY_W    = KEY_W_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter int unsigned MAX_FAIL = MAX_FAIL_DEF,
  parameter int unsigned FAIL_W   = FAIL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              kin_valid_i,
  input  logic              kin_bit_i,
  output logic              kin_ready_o,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_valid_o,
  output logic              busy_o,
  output logic              load_err_o,
  output logic [FAIL_W-1:0] fail_cnt_o,
  output logic              locked_o,
  input  logic [OUT_W-1:0]  obf_in_i,
  output logic [OUT_W-1:0]  obf_out_o
);

  if (MAX_FAIL > (2 ** FAIL_W) - 1) begin : g_bad_cfg
    $error("FAIL_W too narrow for MAX_FAIL");
  end

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              load_err_q, load_err_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;

  logic              shreg_clr;
  logic              xfer;
  logic [KEY_W-1:0]  shadow;
  logic              parity;
  logic              parity_done;
  logic              parity_ok;

  // Ready drops once the parity bit is in, so nothing is taken during the hand-off to CHECK.
  assign kin_ready_o = (state_q == StShift) && !parity_done;
  assign xfer        = kin_valid_i && kin_ready_o;
  assign parity_ok   = (parity_of(32'(shadow)) ^ parity) == 1'b0;

  antisat_key_shreg #(
    .KEY_W(KEY_W)
  ) u_shreg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (shreg_clr),
    .shift_en_i (xfer),
    .bit_i      (kin_bit_i),
    .shadow_o   (shadow),
    .parity_o   (parity),
    .last_bit_o (parity_done)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    load_err_d  = 1'b0;
    fail_cnt_d  = fail_cnt_q;
    shreg_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StShift;
          shreg_clr = 1'b1;
        end
      end
      StShift: begin
        if (parity_done) state_d = StCheck;
      end
      StCheck: begin
        if (parity_ok) begin
          key_d       = shadow;
          key_valid_d = 1'b1;
          state_d     = StActive;
        end else begin
          load_err_d = 1'b1;
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + FAIL_W'(1);
          state_d = StIdle;
`ifdef ANTISAT_LOCKOUT_EN
          if (fail_cnt_d >= FAIL_W'(MAX_FAIL)) state_d = StLockout;
`endif
        end
      end
      StActive: begin
        if (start_i) begin
          key_d       = '0;
          key_valid_d = 1'b0;
          state_d     = StShift;
          shreg_clr   = 1'b1;
        end
      end
`ifdef ANTISAT_LOCKOUT_EN
      StLockout: begin
        key_d       = '0;
        key_valid_d = 1'b0;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      load_err_q  <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      load_err_q  <= load_err_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;
  assign busy_o      = (state_q == StShift) || (state_q == StCheck);
  assign load_err_o  = load_err_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign obf_out_o   = key_valid_q ? obf_in_i : '0;

`ifdef ANTISAT_LOCKOUT_EN
  assign locked_o = (state_q == StLockout);
`else
  assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_antisat_key_loader.sv
// Scoreboard bench for antisat_key_loader; lockout checks when ANTISAT_LOCKOUT_EN is defined.
module tb_antisat_key_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kin_valid;
  logic        kin_bit;
  logic        kin_ready;
  logic [10:0] key;
  logic        key_valid;
  logic        busy;
  logic        load_err;
  logic [1:0]  fail_cnt;
  logic        locked;
  logic [1:0]  obf_in;
  logic [1:0]  obf_out;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_fail = 0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  antisat_key_loader u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .kin_valid_i (kin_valid),
    .kin_bit_i   (kin_bit),
    .kin_ready_o (kin_ready),
    .key_o       (key),
    .key_valid_o (key_valid),
    .busy_o      (busy),
    .load_err_o  (load_err),
    .fail_cnt_o  (fail_cnt),
    .locked_o    (locked),
    .obf_in_i    (obf_in),
    .obf_out_o   (obf_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_key"}, 32'(key), 0);
    check_eq({tag, "_key_valid"}, 32'(key_valid), 0);
    check_eq({tag, "_kin_ready"}, 32'(kin_ready), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_load_err"}, 32'(load_err), 0);
    check_eq({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
    check_eq({tag, "_locked"}, 32'(locked), 0);
    check_eq({tag, "_obf_out"}, 32'(obf_out), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    int budget;
    if (gaps) begin
      kin_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    kin_valid = 1'b1;
    kin_bit   = b;
    budget    = 0;
    while (!kin_ready && budget < 20) begin
      tick();
      budget++;
    end
    if (!kin_ready) check_eq("ready_timeout", 32'(kin_ready), 1);
    tick();
    kin_valid = 1'b0;
  endtask

  task automatic send_key(input logic [10:0] k, input logic par, input bit gaps);
    for (int i = 0; i < 11; i++) send_bit(k[i], gaps);
    send_bit(par, gaps);
  endtask

  // Called right after the parity edge; the commit must land exactly two edges later.
  task automatic wait_commit(input string tag);
    int edges;
    logic [10:0] exp_key;
    edges = 0;
    while (!key_valid && edges < 6) begin
      tick();
      edges++;
    end
    check_eq({tag, "_latency"}, 32'(edges), 2);
    exp_key = (sb_q.size() > 0) ? sb_q.pop_front() : 11'hx;
    check_eq({tag, "_key"}, 32'(key), 32'(exp_key));
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic good_load(input string tag, input logic [10:0] k, input bit gaps);
    sb_q.push_back(k);
    send_key(k, ^k, gaps);
    wait_commit(tag);
  endtask

  task automatic bad_load(input string tag, input logic [10:0] k);
    pulse_start();
    send_key(k, ~(^k), 1'b0);
    tick();
    check_eq({tag, "_check_busy"}, 32'(busy), 1);
    check_eq({tag, "_check_err"}, 32'(load_err), 0);
    tick();
    if (exp_fail < 3) exp_fail++;
    check_eq({tag, "_err"}, 32'(load_err), 1);
    check_eq({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(exp_fail));
    check_eq({tag, "_key_valid"}, 32'(key_valid), 0);
    check_eq({tag, "_kin_ready"}, 32'(kin_ready), 0);
    check_eq({tag, "_obf_out"}, 32'(obf_out), 0);
    tick();
    check_eq({tag, "_err_pulse"}, 32'(load_err), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    kin_valid = 1'b0;
    kin_bit   = 1'b0;
    obf_in    = 2'b11;
    repeat (3) tick();
    check_all_zero("in_reset");
    rst_n = 1'b1;
    repeat (10) tick();
    check_all_zero("idle");

    // Good load of 11'h5A3 (even weight, parity 0).
    pulse_start();
    check_eq("start_ready", 32'(kin_ready), 1);
    check_eq("start_busy", 32'(busy), 1);
    good_load("load_5a3", 11'h5A3, 1'b0);
    check_eq("obf_11", 32'(obf_out), 32'(2'b11));
    obf_in = 2'b10;
    #1 check_eq("obf_10", 32'(obf_out), 32'(2'b10));

    // Same key, wrong parity, reloaded from ACTIVE.
    bad_load("bad_5a3", 11'h5A3);

    // Good load again, then reload 7FF from ACTIVE with random gaps.
    pulse_start();
    good_load("reload_5a3", 11'h5A3, 1'b0);
    pulse_start();
    check_eq("reload_kv_drop", 32'(key_valid), 0);
    check_eq("reload_key_clr", 32'(key), 0);
    check_eq("reload_obf", 32'(obf_out), 0);
    good_load("load_7ff", 11'h7FF, 1'b1);
    check_eq("obf_7ff", 32'(obf_out), 32'(obf_in));

    // Asynchronous reset in the middle of SHIFT.
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_fail = 0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Start together with a valid bit: that bit must not be consumed.
    start     = 1'b1;
    kin_valid = 1'b1;
    kin_bit   = 1'b1;
    tick();
    start     = 1'b0;
    kin_valid = 1'b0;
    good_load("load_001", 11'h001, 1'b0);

`ifdef ANTISAT_LOCKOUT_EN
    bad_load("lk1", 11'h0F0);
    bad_load("lk2", 11'h123);
    bad_load("lk3", 11'h456);
    check_eq("lock_locked", 32'(locked), 1);
    check_eq("lock_fail_cnt", 32'(fail_cnt), 3);
    pulse_start();
    tick();
    check_eq("lock_start_ready", 32'(kin_ready), 0);
    check_eq("lock_start_busy", 32'(busy), 0);
    check_eq("lock_still", 32'(locked), 1);
    rst_n = 1'b0;
    #1 check_eq("lock_reset", 32'(locked), 0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    bad_load("sat1", 11'h0F0);
    bad_load("sat2", 11'h123);
    bad_load("sat3", 11'h456);
    bad_load("sat4", 11'h789);
    check_eq("nolock_locked", 32'(locked), 0);
    pulse_start();
    check_eq("nolock_restart", 32'(kin_ready), 1);
    good_load("load_2aa", 11'h2AA, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
